bsg_mul_iterative_rr_sched: RTL and testbench
=============================================

Name: bsg_mul_iterative_rr_sched

Overview:
Round-robin scheduler that shares one bsg_mul_iterative instance among num_req_p requesters.
- Arbitrates requester valid/ready ports and latches the winning operands.
- Issues one multiply at a time to the multiplier, captures its result and returns it only to the requester that issued it.
- Sits between execution lanes and a single instantiated multiplier. The multiplier is outside this block; its ports connect to the mul_* ports.

Parameters:
width_p, 32, operand width; must match the multiplier's width_p
num_req_p, 4, number of requesters; must be >= 1
full_sized_p, 1, 1 gives a 2*width_p result, 0 gives width_p; must match the multiplier
output_size_lp, derived, full_sized_p ? 2*width_p : width_p
tag_width_lp, derived, BSG_SAFE_CLOG2(num_req_p)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
v_i  in  num_req_p  request valid, one bit per requester
ready_o  out  num_req_p  request accepted when v_i[i] & ready_o[i]
opA_i  in  num_req_p x width_p  operand A per requester
opA_is_signed_i  in  num_req_p  signedness of A per requester
opB_i  in  num_req_p x width_p  operand B per requester
opB_is_signed_i  in  num_req_p  signedness of B per requester
v_o  out  num_req_p  response valid; at most one bit set
result_o  out  output_size_lp  shared result bus, meaningful only where v_o is set
yumi_i  in  num_req_p  response consumed
mul_v_o  out  1  to multiplier v_i
mul_ready_i  in  1  from multiplier ready_o
mul_opA_o / mul_opB_o  out  width_p  operands to multiplier
mul_opA_is_signed_o / mul_opB_is_signed_o  out  1  signedness to multiplier
mul_result_i  in  output_size_lp  from multiplier result_o
mul_v_i  in  1  from multiplier v_o
mul_yumi_o  out  1  to multiplier yumi_i

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = eIDLE; all ready_o, v_o, mul_v_o, mul_yumi_o = 0.
  - Operand, result and tag registers = 0.
  - last_grant_r = num_req_p-1, so requester 0 has top priority first.
- eIDLE:
  - ready_o = one-hot round-robin grant over v_i. Search starts at last_grant_r+1 and wraps modulo num_req_p.
  - ready_o is all-zero if v_i is all-zero, and in every state other than eIDLE.
  - ready_o may depend combinationally on v_i. The sub-module keeps this path purely combinational.
  - On accept: latch opA, opB, both sign bits and tag = granted index; last_grant_r <= granted index; go to eISSUE.
- eISSUE:
  - mul_v_o = 1; mul_op* driven from registers only.
  - When mul_ready_i = 1 the multiplier has taken the operands; go to eWAIT. Otherwise hold.
- eWAIT:
  - mul_yumi_o = mul_v_i, combinationally.
  - On mul_v_i: result_r <= mul_result_i; go to eRESP.
- eRESP:
  - v_o[tag_r] = 1; result_o = result_r.
  - On yumi_i[tag_r]: go to eIDLE.
  - yumi_i bits other than tag_r are ignored.
  - A new grant is first possible on the cycle after the eRESP handshake.
- Timing:
  - v_o rises exactly one cycle after the mul_v_i & mul_yumi_o cycle.
  - Added overhead is one eIDLE accept cycle, at least one eISSUE cycle and one eRESP cycle, plus the multiplier's own latency.
- Fairness: a requester holding v_i high is granted within num_req_p accepts.
- Simultaneous events: v_i asserted in any state other than eIDLE is simply not accepted. The requester must hold v_i and its operands until ready_o.
- num_req_p = 1: the arbiter degenerates to ready_o = v_i in eIDLE; the tag is a constant 0.
- Reset mid-operation:
  - Returns to eIDLE immediately; v_o clears asynchronously; the in-flight result is discarded.
  - The integrator must reset the multiplier in the same event, because the multiplier has no abort.
- States are never illegal; default transitions to eIDLE.

Optional Feature:
Macro: BSG_MUL_SCHED_ZERO_BYPASS_EN
- Defined:
  - In eIDLE, an accepted request with opA == 0 or opB == 0 goes directly to eRESP with result_r = 0.
  - The multiplier is not used for that request. Accept-to-v_o latency is 1 cycle.
  - last_grant_r still updates.
- Undefined: every request goes through eISSUE/eWAIT. No zero-detect logic is built.

Decomposition:
- Package bsg_mul_sched_pkg holds:
  - the state_e enum {eIDLE, eISSUE, eWAIT, eRESP} (2 bits);
  - width helper constants.
- Sub-module bsg_mul_sched_rr_arb: combinational round-robin grant from (v_i, last_grant_r, en_i), producing a one-hot grant and its encoded index.

Test Plan:
- Single requester: req 2, opA=7, opB=6, unsigned, with a multiplier model of 5-cycle latency → ready_o = 4'b0100 for one cycle; v_o = 4'b0100 with result 42 one cycle after the mul handshake; yumi_i[2] returns the block to eIDLE.
- Signed: req 0, opA = -3 (0xFFFFFFFD) signed, opB = 5 signed, full_sized_p=1 → result_o = 64'hFFFFFFFFFFFFFFF1; mul_*_is_signed_o = 1 during eISSUE.
- Fairness: all four v_i held high from reset, each request completed → grant order 0,1,2,3,0; no requester is granted twice before the others.
- Backpressure: mul_ready_i held low 3 cycles in eISSUE; yumi_i[tag] withheld 4 cycles in eRESP → mul_v_o stays high; v_o and result_o stay stable; ready_o = 0 throughout; a wrong-index yumi_i is ignored.
- Reset during eWAIT: deassert reset_n_i → v_o, mul_v_o and ready_o are 0 the same cycle; after release, req 0 is granted first.
- Zero bypass (macro defined): req 1, opA=0, opB=0x1234 → v_o[1] one cycle after accept with result 0; mul_v_o never asserts.

Source files
------------

// File: rtl/bsg_mul_sched_pkg.sv
// Shared types and width helpers for the round-robin multiplier scheduler.
package bsg_mul_sched_pkg;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eISSUE = 2'd1,
        eWAIT  = 2'd2,
        eRESP  = 2'd3
    } state_e;

    localparam int unsigned StateWidth = 2;

    // Matches BSG_SAFE_CLOG2: a single requester still needs a 1-bit tag.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned output_size(input int unsigned width,
                                                input int unsigned full_sized);
        return (full_sized != 0) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/bsg_mul_sched_rr_arb.sv
// Combinational round-robin arbiter: search starts one past the last grant and wraps.
module bsg_mul_sched_rr_arb
    import bsg_mul_sched_pkg::*;
#(
    parameter  int unsigned num_req_p    = 4,
    localparam int unsigned tag_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]    v_i,
    input  logic [tag_width_lp-1:0] last_grant_i,
    input  logic                    en_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic [tag_width_lp-1:0] grant_idx_o,
    output logic                    grant_v_o
);

    logic [tag_width_lp-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_v_o   = 1'b0;
        idx         = '0;
        for (int unsigned off = 1; off <= num_req_p; off++) begin
            idx = tag_width_lp'((32'(last_grant_i) + off) % num_req_p);
            if (en_i && !grant_v_o && v_i[idx]) begin
                grant_v_o    = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/bsg_mul_iterative_rr_sched.sv
// Shares one iterative multiplier among num_req_p requesters, one multiply in flight at a time.
// Optional BSG_MUL_SCHED_ZERO_BYPASS_EN answers zero-operand requests without the multiplier.
module bsg_mul_iterative_rr_sched
    import bsg_mul_sched_pkg::*;
#(
    parameter  int unsigned width_p        = 32,
    parameter  int unsigned num_req_p      = 4,
    parameter  int unsigned full_sized_p   = 1,
    localparam int unsigned output_size_lp = output_size(width_p, full_sized_p),
    localparam int unsigned tag_width_lp   = safe_clog2(num_req_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p-1:0]                v_i,
    output logic [num_req_p-1:0]                ready_o,
    input  logic [num_req_p-1:0][width_p-1:0]   opA_i,
    input  logic [num_req_p-1:0]                opA_is_signed_i,
    input  logic [num_req_p-1:0][width_p-1:0]   opB_i,
    input  logic [num_req_p-1:0]                opB_is_signed_i,
    output logic [num_req_p-1:0]                v_o,
    output logic [output_size_lp-1:0]           result_o,
    input  logic [num_req_p-1:0]                yumi_i,
    output logic                                mul_v_o,
    input  logic                                mul_ready_i,
    output logic [width_p-1:0]                  mul_opA_o,
    output logic [width_p-1:0]                  mul_opB_o,
    output logic                                mul_opA_is_signed_o,
    output logic                                mul_opB_is_signed_o,
    input  logic [output_size_lp-1:0]           mul_result_i,
    input  logic                                mul_v_i,
    output logic                                mul_yumi_o
);

    localparam logic [tag_width_lp-1:0] LastGrantInit = tag_width_lp'(num_req_p - 1);

    state_e                    state_q, state_d;
    logic [tag_width_lp-1:0]   last_grant_q, last_grant_d;
    logic [tag_width_lp-1:0]   tag_q, tag_d;
    logic [width_p-1:0]        opA_q, opA_d;
    logic [width_p-1:0]        opB_q, opB_d;
    logic                      opA_signed_q, opA_signed_d;
    logic                      opB_signed_q, opB_signed_d;
    logic [output_size_lp-1:0] result_q, result_d;

    logic [num_req_p-1:0]      arb_grant;
    logic [tag_width_lp-1:0]   arb_idx;
    logic                      arb_v;
    logic [width_p-1:0]        sel_opA;
    logic [width_p-1:0]        sel_opB;

    // Gating with reset keeps ready_o low while reset is held, even with v_i asserted.
    bsg_mul_sched_rr_arb #(
        .num_req_p (num_req_p)
    ) u_arb (
        .v_i          (v_i),
        .last_grant_i (last_grant_q),
        .en_i         ((state_q == eIDLE) && reset_n_i),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .grant_v_o    (arb_v)
    );

    assign sel_opA = opA_i[arb_idx];
    assign sel_opB = opB_i[arb_idx];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        opA_signed_d = opA_signed_q;
        opB_signed_d = opB_signed_q;
        result_d     = result_q;
        unique case (state_q)
            eIDLE: begin
                if (arb_v) begin
                    opA_d        = sel_opA;
                    opB_d        = sel_opB;
                    opA_signed_d = opA_is_signed_i[arb_idx];
                    opB_signed_d = opB_is_signed_i[arb_idx];
                    tag_d        = arb_idx;
                    last_grant_d = arb_idx;
                    state_d      = eISSUE;
`ifdef BSG_MUL_SCHED_ZERO_BYPASS_EN
                    if ((sel_opA == '0) || (sel_opB == '0)) begin
                        result_d = '0;
                        state_d  = eRESP;
                    end
`endif
                end
            end
            eISSUE: begin
                if (mul_ready_i) begin
                    state_d = eWAIT;
                end
            end
            eWAIT: begin
                if (mul_v_i) begin
                    result_d = mul_result_i;
                    state_d  = eRESP;
                end
            end
            eRESP: begin
                if (yumi_i[tag_q]) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= eIDLE;
            last_grant_q <= LastGrantInit;
            tag_q        <= '0;
            opA_q        <= '0;
            opB_q        <= '0;
            opA_signed_q <= 1'b0;
            opB_signed_q <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            opA_signed_q <= opA_signed_d;
            opB_signed_q <= opB_signed_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        v_o = '0;
        if (state_q == eRESP) begin
            v_o[tag_q] = 1'b1;
        end
    end

    assign ready_o             = arb_grant;
    assign result_o            = result_q;
    assign mul_v_o             = (state_q == eISSUE);
    assign mul_yumi_o          = (state_q == eWAIT) && mul_v_i;
    assign mul_opA_o           = opA_q;
    assign mul_opB_o           = opB_q;
    assign mul_opA_is_signed_o = opA_signed_q;
    assign mul_opB_is_signed_o = opB_signed_q;

endmodule

// File: tb/tb_bsg_mul_iterative_rr_sched.sv
// Bench for bsg_mul_iterative_rr_sched with a latency-configurable multiplier stand-in.
// Build with BSG_MUL_SCHED_ZERO_BYPASS_EN to also exercise the zero-operand bypass.
module tb_bsg_mul_iterative_rr_sched;

    logic              clk_i = 1'b0;
    logic              reset_n;
    logic [3:0]        v_i;
    logic [3:0]        ready_o;
    logic [3:0][31:0]  opA;
    logic [3:0]        opA_s;
    logic [3:0][31:0]  opB;
    logic [3:0]        opB_s;
    logic [3:0]        v_o;
    logic [63:0]       result_o;
    logic [3:0]        yumi_i;
    logic              mul_v_o;
    logic              mul_ready_i;
    logic [31:0]       mul_opA_o;
    logic [31:0]       mul_opB_o;
    logic              mul_opA_is_signed_o;
    logic              mul_opB_is_signed_o;
    logic [63:0]       mul_result_i;
    logic              mul_v_i;
    logic              mul_yumi_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_until = 0;
    int mul_lat = 5;

    always #5 clk_i = ~clk_i;

    bsg_mul_iterative_rr_sched #(
        .width_p      (32),
        .num_req_p    (4),
        .full_sized_p (1)
    ) dut (
        .clk_i               (clk_i),
        .reset_n_i           (reset_n),
        .v_i                 (v_i),
        .ready_o             (ready_o),
        .opA_i               (opA),
        .opA_is_signed_i     (opA_s),
        .opB_i               (opB),
        .opB_is_signed_i     (opB_s),
        .v_o                 (v_o),
        .result_o            (result_o),
        .yumi_i              (yumi_i),
        .mul_v_o             (mul_v_o),
        .mul_ready_i         (mul_ready_i),
        .mul_opA_o           (mul_opA_o),
        .mul_opB_o           (mul_opB_o),
        .mul_opA_is_signed_o (mul_opA_is_signed_o),
        .mul_opB_is_signed_o (mul_opB_is_signed_o),
        .mul_result_i        (mul_result_i),
        .mul_v_i             (mul_v_i),
        .mul_yumi_o          (mul_yumi_o)
    );

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    function automatic logic [3:0] rr(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return 4'b0001 << ((last + k) % 4);
        end
        return 4'b0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Multiplier stand-in: fixed latency, holds its result until yumi.
    logic        mm_busy;
    logic        mm_done;
    int          mm_cnt;
    logic [63:0] mm_res;

    assign mul_ready_i  = !mm_busy && (cyc >= stall_until);
    assign mul_v_i      = mm_done;
    assign mul_result_i = mm_res;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            mm_busy <= 1'b0;
            mm_done <= 1'b0;
            mm_cnt  <= 0;
            mm_res  <= '0;
        end else if (mm_done) begin
            if (mul_yumi_o) begin
                mm_done <= 1'b0;
                mm_busy <= 1'b0;
            end
        end else if (mm_busy) begin
            if (mm_cnt <= 1) mm_done <= 1'b1;
            else mm_cnt <= mm_cnt - 1;
        end else if (mul_v_o && mul_ready_i) begin
            mm_busy <= 1'b1;
            mm_cnt  <= mul_lat;
            mm_res  <= prod(mul_opA_o, mul_opB_o, mul_opA_is_signed_o, mul_opB_is_signed_o);
        end
    end

    // Transaction-level reference: one request owned at a time, answered to its issuer.
    initial begin
        bit          m_busy, m_issued, m_resp;
        int          m_last, m_tag;
        logic [31:0] m_a, m_b;
        logic        m_sa, m_sb;
        logic [63:0] m_res;
        logic [3:0]  exp_ready, exp_vo;
        logic        exp_mulv, exp_yumi;
        m_busy = 0; m_issued = 0; m_resp = 0; m_last = 3; m_tag = 0;
        m_a = '0; m_b = '0; m_sa = 0; m_sb = 0; m_res = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_n) begin
                m_busy = 0; m_issued = 0; m_resp = 0; m_last = 3;
                chk("rst_ready", ready_o, 4'b0);
                chk("rst_v_o", v_o, 4'b0);
                chk("rst_mul_v", mul_v_o, 1'b0);
                chk("rst_mul_yumi", mul_yumi_o, 1'b0);
            end else begin
                exp_ready = m_busy ? 4'b0 : rr(v_i, m_last);
                exp_vo    = m_resp ? (4'b0001 << m_tag) : 4'b0;
                exp_mulv  = m_busy && !m_issued && !m_resp;
                exp_yumi  = m_busy && m_issued && !m_resp && mul_v_i;
                chk("cyc_ready", ready_o, exp_ready);
                chk("cyc_v_o", v_o, exp_vo);
                chk("cyc_mul_v", mul_v_o, exp_mulv);
                chk("cyc_mul_yumi", mul_yumi_o, exp_yumi);
                if (m_resp) chk("cyc_result", result_o, m_res);
                if (exp_mulv) chk("cyc_mul_ops",
                                  {mul_opA_o, mul_opB_o[29:0], mul_opA_is_signed_o,
                                   mul_opB_is_signed_o},
                                  {m_a, m_b[29:0], m_sa, m_sb});
                if (exp_ready != 4'b0) begin
                    for (int k = 0; k < 4; k++) if (exp_ready[k]) m_tag = k;
                    m_a = opA[m_tag]; m_b = opB[m_tag];
                    m_sa = opA_s[m_tag]; m_sb = opB_s[m_tag];
                    m_res = prod(m_a, m_b, m_sa, m_sb);
                    m_last = m_tag; m_busy = 1; m_issued = 0; m_resp = 0;
`ifdef BSG_MUL_SCHED_ZERO_BYPASS_EN
                    if (m_a == 0 || m_b == 0) begin
                        m_resp = 1;
                        m_res = '0;
                    end
`endif
                end else if (m_resp && yumi_i[m_tag]) begin
                    m_busy = 0; m_issued = 0; m_resp = 0;
                end else if (exp_mulv && mul_ready_i) begin
                    m_issued = 1;
                end else if (exp_yumi) begin
                    m_resp = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(input int idx, input string name);
        int n;
        n = 0;
        while (!ready_o[idx] && n < 40) begin
            step();
            n++;
        end
        if (!ready_o[idx]) tmo(name);
    endtask

    task automatic wait_mul_hs(input string name);
        int n;
        n = 0;
        while (!(mul_v_i && mul_yumi_o) && n < 60) begin
            step();
            n++;
        end
        if (!(mul_v_i && mul_yumi_o)) tmo(name);
    endtask

    task automatic run_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic sa, input logic sb, input logic [63:0] exp_res,
                           input string name);
        v_i[idx] = 1'b1; opA[idx] = a; opB[idx] = b; opA_s[idx] = sa; opB_s[idx] = sb;
        #1;
        wait_ready(idx, {name, "_ready_wait"});
        chk({name, "_ready"}, ready_o, 4'b0001 << idx);
        step();
        v_i[idx] = 1'b0;
        chk({name, "_mul_v"}, mul_v_o, 1'b1);
        chk({name, "_signs"}, {mul_opA_is_signed_o, mul_opB_is_signed_o}, {sa, sb});
        wait_mul_hs({name, "_hs_wait"});
        step();
        chk({name, "_v_o"}, v_o, 4'b0001 << idx);
        chk({name, "_result"}, result_o, exp_res);
        yumi_i[idx] = 1'b1;
        step();
        yumi_i = '0;
        chk({name, "_v_o_done"}, v_o, 4'b0);
    endtask

    initial begin
        logic [63:0] held;
        int          n;
        reset_n = 1'b0;
        v_i = '0; yumi_i = '0; opA = '0; opB = '0; opA_s = '0; opB_s = '0;
        step();
        chk("reset_result", result_o, 64'h0);
        chk("reset_v_o", v_o, 4'b0);
        step();
        reset_n = 1'b1;
        step();

        run_req(2, 32'd7, 32'd6, 1'b0, 1'b0, 64'd42, "single");
        run_req(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "signed");

        // Backpressure: multiplier refuses 3 issue cycles, consumer withholds yumi 4 cycles.
        v_i[3] = 1'b1; opA[3] = 32'd100; opB[3] = 32'd3; opA_s[3] = 1'b0; opB_s[3] = 1'b0;
        #1;
        wait_ready(3, "bp_ready_wait");
        step();
        stall_until = cyc + 3;
        v_i[3] = 1'b0;
        v_i[0] = 1'b1; opA[0] = 32'd1; opB[0] = 32'd1; opA_s[0] = 1'b0; opB_s[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp_mul_v_held", mul_v_o, 1'b1);
            chk("bp_ready_zero", ready_o, 4'b0);
            step();
        end
        v_i[0] = 1'b0;
        wait_mul_hs("bp_hs_wait");
        step();
        chk("bp_v_o", v_o, 4'b1000);
        chk("bp_result", result_o, 64'd300);
        held = result_o;
        for (int k = 0; k < 4; k++) begin
            yumi_i = (k == 1) ? 4'b0001 : 4'b0000;
            step();
            chk("bp_v_o_stable", v_o, 4'b1000);
            chk("bp_result_stable", result_o, held);
        end
        yumi_i = 4'b1000;
        step();
        yumi_i = '0;
        chk("bp_v_o_done", v_o, 4'b0);

        // Reset while the multiply is in flight.
        v_i[1] = 1'b1; opA[1] = 32'd9; opB[1] = 32'd9;
        #1;
        wait_ready(1, "rstw_ready_wait");
        step();
        v_i[1] = 1'b0;
        n = 0;
        while (mul_v_o && n < 20) begin
            step();
            n++;
        end
        if (mul_v_o) tmo("rstw_issue_wait");
        for (int k = 0; k < 4; k++) begin
            opA[k] = 32'(k + 2); opB[k] = 32'(k + 10); opA_s[k] = 1'b0; opB_s[k] = 1'b0;
        end
        v_i = 4'b1111;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstw_v_o", v_o, 4'b0);
        chk("rstw_mul_v", mul_v_o, 1'b0);
        chk("rstw_ready", ready_o, 4'b0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("rstw_first_grant", ready_o, 4'b0001);

        // Fairness with every requester holding v_i.
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (ready_o == 4'b0 && n < 40) begin
                step();
                n++;
            end
            chk("fair_grant", ready_o, 4'b0001 << (k % 4));
            step();
            n = 0;
            while (v_o == 4'b0 && n < 40) begin
                step();
                n++;
            end
            chk("fair_v_o", v_o, 4'b0001 << (k % 4));
            chk("fair_result", result_o, 64'((k % 4 + 2) * (k % 4 + 10)));
            yumi_i = v_o;
            step();
            yumi_i = '0;
        end
        v_i = '0;
        step();

        // Reset while a response is pending: v_o drops without waiting for a clock.
        v_i[2] = 1'b1; opA[2] = 32'd5; opB[2] = 32'd5;
        #1;
        wait_ready(2, "rstr_ready_wait");
        step();
        v_i[2] = 1'b0;
        n = 0;
        while (v_o == 4'b0 && n < 40) begin
            step();
            n++;
        end
        chk("rstr_v_o_before", v_o, 4'b0100);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstr_v_o", v_o, 4'b0);
        chk("rstr_result", result_o, 64'h0);
        step();
        reset_n = 1'b1;
        step();

`ifdef BSG_MUL_SCHED_ZERO_BYPASS_EN
        v_i[1] = 1'b1; opA[1] = 32'h0; opB[1] = 32'h1234; opA_s[1] = 1'b0; opB_s[1] = 1'b0;
        #1;
        wait_ready(1, "zb_ready_wait");
        chk("zb_ready", ready_o, 4'b0010);
        step();
        v_i[1] = 1'b0;
        chk("zb_v_o", v_o, 4'b0010);
        chk("zb_result", result_o, 64'h0);
        chk("zb_mul_v", mul_v_o, 1'b0);
        yumi_i[1] = 1'b1;
        step();
        yumi_i = '0;
        chk("zb_v_o_done", v_o, 4'b0);
        chk("zb_mul_v_after", mul_v_o, 1'b0);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
